// File: rtl/sync_s2f_evt.sv
// rtl/sync_s2f_evt.sv - multi-channel slow-to-fast event synchroniser
// Each channel: N-flop sync chain, edge detect, registered pulse, pending/ack and sticky overflow.
module sync_s2f_evt #(
  parameter int NCH       = 1,
  parameter int SYNC_STG  = 2,
  parameter int EDGE_MODE = 0
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [NCH-1:0] evt_i,
  output logic [NCH-1:0] level_o,
  output logic [NCH-1:0] pulse_o,
  output logic [NCH-1:0] pend_o,
  input  logic [NCH-1:0] ack_i,
  output logic [NCH-1:0] ovf_o,
  input  logic           ovf_clr_i
);

  if (SYNC_STG < 2 || SYNC_STG > 4 || EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_param
    $error("sync_s2f_evt: SYNC_STG must be 2..4 and EDGE_MODE 0..2");
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic [SYNC_STG:1] s;
    logic              h;
    logic              rise;
    logic              fall;
    logic              det;
    logic              pulse;
    logic              pend;
    logic              ovf;

    // s[1] is the metastability-exposed flop; only s[SYNC_STG] is used downstream
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        s <= '0;
        h <= 1'b0;
      end else begin
        s <= {s[SYNC_STG-1:1], evt_i[ch]};
        h <= s[SYNC_STG];
      end
    end

    assign rise = s[SYNC_STG] & ~h;
    assign fall = ~s[SYNC_STG] & h;

    if (EDGE_MODE == 0) begin : g_rise
      assign det = rise;
    end else if (EDGE_MODE == 1) begin : g_fall
      assign det = fall;
    end else begin : g_both
      assign det = rise | fall;
    end

    // A new edge takes precedence over ack so it is never silently dropped
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        pulse <= 1'b0;
        pend  <= 1'b0;
        ovf   <= 1'b0;
      end else begin
        pulse <= det;
        if (det && pend && !ack_i[ch]) begin
          pend <= 1'b1;
          ovf  <= 1'b1;
        end else begin
          if (det) begin
            pend <= 1'b1;
          end else if (ack_i[ch]) begin
            pend <= 1'b0;
          end
          if (ovf_clr_i) begin
            ovf <= 1'b0;
          end
        end
      end
    end

    assign level_o[ch] = s[SYNC_STG];
    assign pulse_o[ch] = pulse;
    assign pend_o[ch]  = pend;
    assign ovf_o[ch]   = ovf;
  end

endmodule

// File: tb/tb_sync_s2f_evt.sv
// tb/tb_sync_s2f_evt.sv - self-checking bench for sync_s2f_evt
// Three single-channel instances (rise/fall/both) share one input; a 4-channel instance runs random traffic.
module tb_sync_s2f_evt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0;
  int errs = 0;

  logic rstn, evt, clr_r, clr_z;
  logic ack_r, ack_f, ack_b;
  logic level_r, pulse_r, pend_r, ovf_r;
  logic level_f, pulse_f, pend_f, ovf_f;
  logic level_b, pulse_b, pend_b, ovf_b;

  logic       rstn_m, clr_m;
  logic [3:0] evt_m, level_m, pulse_m, pend_m, ack_m, ovf_m;

  sync_s2f_evt #(.NCH(1), .SYNC_STG(2), .EDGE_MODE(0)) u_r (
    .clk(clk), .rstn(rstn), .evt_i(evt), .level_o(level_r), .pulse_o(pulse_r),
    .pend_o(pend_r), .ack_i(ack_r), .ovf_o(ovf_r), .ovf_clr_i(clr_r));
  sync_s2f_evt #(.NCH(1), .SYNC_STG(2), .EDGE_MODE(1)) u_f (
    .clk(clk), .rstn(rstn), .evt_i(evt), .level_o(level_f), .pulse_o(pulse_f),
    .pend_o(pend_f), .ack_i(ack_f), .ovf_o(ovf_f), .ovf_clr_i(clr_z));
  sync_s2f_evt #(.NCH(1), .SYNC_STG(2), .EDGE_MODE(2)) u_b (
    .clk(clk), .rstn(rstn), .evt_i(evt), .level_o(level_b), .pulse_o(pulse_b),
    .pend_o(pend_b), .ack_i(ack_b), .ovf_o(ovf_b), .ovf_clr_i(clr_z));
  sync_s2f_evt #(.NCH(4), .SYNC_STG(3), .EDGE_MODE(2)) u_m (
    .clk(clk), .rstn(rstn_m), .evt_i(evt_m), .level_o(level_m), .pulse_o(pulse_m),
    .pend_o(pend_m), .ack_i(ack_m), .ovf_o(ovf_m), .ovf_clr_i(clr_m));

  // Scoreboards hold the cycle number at which each expected pulse is visible
  int q_r[$];
  int q_f[$];
  int q_b[$];
  typedef struct { int c; int ch; } ent_t;
  ent_t qm[$];

  function automatic logic sb_pop(input int sel);
    logic e;
    e = 1'b0;
    case (sel)
      0: if (q_r.size() > 0 && q_r[0] == cyc) begin e = 1'b1; void'(q_r.pop_front()); end
      1: if (q_f.size() > 0 && q_f[0] == cyc) begin e = 1'b1; void'(q_f.pop_front()); end
      default: if (q_b.size() > 0 && q_b[0] == cyc) begin e = 1'b1; void'(q_b.pop_front()); end
    endcase
    return e;
  endfunction

  function automatic logic [3:0] sb_pop_m();
    logic [3:0] e;
    e = '0;
    while (qm.size() > 0 && qm[0].c <= cyc) begin
      if (qm[0].c == cyc) e[qm[0].ch] = 1'b1;
      void'(qm.pop_front());
    end
    return e;
  endfunction

  task automatic test_reset;
    int mexp;
    logic er, ef, eb;
    rstn = 1'b0; rstn_m = 1'b0; evt = 1'b1; evt_m = 4'hF;
    ack_r = 1'b1; ack_f = 1'b1; ack_b = 1'b1; ack_m = 4'h0;
    clr_r = 1'b0; clr_z = 1'b0; clr_m = 1'b0;
    repeat (3) @(negedge clk);
    vecs++;
    if ({level_r, pulse_r, pend_r, ovf_r, level_b, pulse_b} !== 6'b0) begin
      errs++; $display("FAIL reset_hold_1ch: got %b expected 0", {level_r, pulse_r, pend_r, ovf_r, level_b, pulse_b});
    end
    vecs++;
    if ({level_m, pulse_m, pend_m, ovf_m} !== 16'h0) begin
      errs++; $display("FAIL reset_hold_4ch: got %h expected 0", {level_m, pulse_m, pend_m, ovf_m});
    end
    rstn = 1'b1; rstn_m = 1'b1;
    q_r.push_back(cyc + 3); q_b.push_back(cyc + 3);
    mexp = cyc + 4;
    #1;
    vecs++;
    if ({level_r, pulse_r, pend_r, ovf_r, level_m, pulse_m, pend_m, ovf_m} !== 20'h0) begin
      errs++; $display("FAIL reset_release: got %h expected 0", {level_r, pulse_r, pend_r, ovf_r, level_m, pulse_m, pend_m, ovf_m});
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      er = sb_pop(0); ef = sb_pop(1); eb = sb_pop(2);
      vecs++;
      if ({pulse_r, pulse_f, pulse_b} !== {er, ef, eb}) begin
        errs++; $display("FAIL reset_pulse cyc %0d: got %b expected %b", cyc, {pulse_r, pulse_f, pulse_b}, {er, ef, eb});
      end
      vecs++;
      if (pulse_m !== ((cyc == mexp) ? 4'hF : 4'h0)) begin
        errs++; $display("FAIL reset_pulse_4ch cyc %0d: got %h expected %h", cyc, pulse_m, (cyc == mexp) ? 4'hF : 4'h0);
      end
    end
  endtask

  task automatic test_modes;
    logic v, er, ef, eb;
    int nr, nf, nb;
    nr = 0; nf = 0; nb = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      er = sb_pop(0); ef = sb_pop(1); eb = sb_pop(2);
      vecs++;
      if ({pulse_r, pulse_f, pulse_b} !== {er, ef, eb}) begin
        errs++; $display("FAIL modes_pulse cyc %0d: got %b expected %b", cyc, {pulse_r, pulse_f, pulse_b}, {er, ef, eb});
      end
      if (k >= 6) begin
        nr += int'(pulse_r); nf += int'(pulse_f); nb += int'(pulse_b);
      end
      v = (k >= 6 && k < 70) ? (((k - 6) / 8) % 2 == 0) : 1'b0;
      if (v != evt) begin
        evt = v;
        if (v) q_r.push_back(cyc + 3); else q_f.push_back(cyc + 3);
        q_b.push_back(cyc + 3);
      end
    end
    vecs++;
    if (nr != 4 || nf != 4 || nb != 8) begin
      errs++; $display("FAIL modes_count: got r%0d f%0d b%0d expected r4 f4 b8", nr, nf, nb);
    end
  endtask

  task automatic test_latency;
    int j;
    ack_r = 1'b0;
    repeat (4) @(negedge clk);
    vecs++;
    if (pend_r !== 1'b0) begin
      errs++; $display("FAIL latency_pre_pend: got %b expected 0", pend_r);
    end
    evt = 1'b1;
    j = cyc + 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vecs++;
      if ({level_r, pulse_r, pend_r} !== {cyc >= j + 1, cyc == j + 2, cyc >= j + 2}) begin
        errs++; $display("FAIL latency edge+%0d: got lvl/pls/pnd %b expected %b", cyc - j,
                         {level_r, pulse_r, pend_r}, {cyc >= j + 1, cyc == j + 2, cyc >= j + 2});
      end
    end
  endtask

  task automatic test_handshake;
    repeat (3) @(negedge clk);
    vecs++;
    if (pend_r !== 1'b1) begin errs++; $display("FAIL hs_pend_held: got %b expected 1", pend_r); end
    ack_r = 1'b1;
    @(negedge clk); ack_r = 1'b0;
    vecs++;
    if (pend_r !== 1'b0) begin errs++; $display("FAIL hs_ack_clear: got %b expected 0", pend_r); end
    evt = 1'b0; repeat (4) @(negedge clk);
    evt = 1'b1; repeat (3) @(negedge clk);
    vecs++;
    if ({pulse_r, pend_r, ovf_r} !== 3'b110) begin
      errs++; $display("FAIL hs_first_edge: got pls/pnd/ovf %b expected 110", {pulse_r, pend_r, ovf_r});
    end
    evt = 1'b0; repeat (4) @(negedge clk);
    evt = 1'b1; repeat (3) @(negedge clk);
    vecs++;
    if ({pulse_r, pend_r, ovf_r} !== 3'b111) begin
      errs++; $display("FAIL hs_overflow: got pls/pnd/ovf %b expected 111", {pulse_r, pend_r, ovf_r});
    end
  endtask

  task automatic test_ovf_clear;
    evt = 1'b0; repeat (4) @(negedge clk);
    evt = 1'b1; repeat (2) @(negedge clk);
    clr_r = 1'b1;
    @(negedge clk); clr_r = 1'b0;
    vecs++;
    if ({pulse_r, ovf_r} !== 2'b11) begin
      errs++; $display("FAIL ovf_set_wins: got pls/ovf %b expected 11", {pulse_r, ovf_r});
    end
    clr_r = 1'b1;
    @(negedge clk); clr_r = 1'b0;
    vecs++;
    if (ovf_r !== 1'b0) begin errs++; $display("FAIL ovf_clear: got %b expected 0", ovf_r); end
  endtask

  task automatic test_ack_coincident;
    evt = 1'b0; repeat (4) @(negedge clk);
    evt = 1'b1; repeat (2) @(negedge clk);
    ack_r = 1'b1;
    @(negedge clk); ack_r = 1'b0;
    vecs++;
    if ({pulse_r, pend_r, ovf_r} !== 3'b110) begin
      errs++; $display("FAIL ack_coincident: got pls/pnd/ovf %b expected 110", {pulse_r, pend_r, ovf_r});
    end
    ack_r = 1'b1;
    @(negedge clk);
    vecs++;
    if (pend_r !== 1'b0) begin errs++; $display("FAIL ack_after: got %b expected 0", pend_r); end
    @(negedge clk); ack_r = 1'b0;
    vecs++;
    if ({pend_r, ovf_r} !== 2'b00) begin
      errs++; $display("FAIL ack_idle_noeffect: got pnd/ovf %b expected 00", {pend_r, ovf_r});
    end
  endtask

  task automatic test_random_mch;
    logic [3:0] e;
    int hold[4];
    int ec[4];
    int gc[4];
    for (int ch = 0; ch < 4; ch++) begin hold[ch] = 0; ec[ch] = 0; gc[ch] = 0; end
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      e = sb_pop_m();
      vecs++;
      if (pulse_m !== e) begin errs++; $display("FAIL rnd1_pulse cyc %0d: got %h expected %h", cyc, pulse_m, e); end
      ack_m = 4'($urandom);
      for (int ch = 0; ch < 4; ch++) begin
        if (hold[ch] > 0) hold[ch]--;
        else if ($urandom_range(0, 1) == 1) begin
          evt_m[ch] = ~evt_m[ch];
          qm.push_back('{cyc + 4, ch});
          hold[ch] = $urandom_range(2, 5);
        end
      end
    end
    @(negedge clk);
    rstn_m = 1'b0; evt_m = 4'h0; ack_m = 4'h0;
    #1;
    vecs++;
    if ({level_m, pulse_m, pend_m, ovf_m} !== 16'h0) begin
      errs++; $display("FAIL rnd_midreset: got %h expected 0", {level_m, pulse_m, pend_m, ovf_m});
    end
    qm.delete();
    repeat (2) @(negedge clk);
    rstn_m = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      vecs++;
      if ({level_m, pulse_m} !== 8'h0) begin
        errs++; $display("FAIL rnd_stray cyc %0d: got lvl/pls %h expected 0", cyc, {level_m, pulse_m});
      end
    end
    for (int k = 0; k < 160; k++) begin
      @(negedge clk);
      e = sb_pop_m();
      vecs++;
      if (pulse_m !== e) begin errs++; $display("FAIL rnd2_pulse cyc %0d: got %h expected %h", cyc, pulse_m, e); end
      for (int ch = 0; ch < 4; ch++) gc[ch] += int'(pulse_m[ch]);
      ack_m = 4'($urandom);
      if (k < 150) begin
        for (int ch = 0; ch < 4; ch++) begin
          if (hold[ch] > 0) hold[ch]--;
          else if ($urandom_range(0, 1) == 1) begin
            evt_m[ch] = ~evt_m[ch];
            qm.push_back('{cyc + 4, ch});
            ec[ch]++;
            hold[ch] = $urandom_range(2, 5);
          end
        end
      end
    end
    for (int ch = 0; ch < 4; ch++) begin
      vecs++;
      if (gc[ch] != ec[ch]) begin errs++; $display("FAIL rnd_count ch%0d: got %0d expected %0d", ch, gc[ch], ec[ch]); end
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_latency();
    test_handshake();
    test_ovf_clear();
    test_ack_coincident();
    test_random_mch();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
